fp_simd_sequencer: RTL

- Initiator for the FP_SIMD request interface (4 lanes x 22-bit floats).
- Accepts queued commands {opcode, in1, in2} from the control path and issues them one at a time to the SIMD unit.
- Holds operands and opcode stable until the SIMD reports o_valid, captures the result and returns it over a valid/ready port.
- Sits between the render control FSM and the FP_SIMD instance.

---
 rtl/fp_simd_pkg.sv | 36 +++
 rtl/simd_cmd_fifo.sv | 60 ++++++
 rtl/fp_simd_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fp_simd_pkg.sv
// Shared definitions for the FP_SIMD unit and its command sequencer:
// vector geometry, opcodes, sequencer states and the queued command layout.
package fp_simd_pkg;

    localparam int SIMD_WIDTH = 4;
    localparam int FP_WIDTH   = 22;
    localparam int VW         = SIMD_WIDTH * FP_WIDTH;

    localparam logic [2:0] OP_ADD        = 3'd0;
    localparam logic [2:0] OP_SUB        = 3'd1;
    localparam logic [2:0] OP_MUL        = 3'd2;
    localparam logic [2:0] OP_RCP        = 3'd3;
    localparam logic [2:0] OP_REDUCE_ADD = 3'd4;
    localparam logic [2:0] OP_REDUCE_MUL = 3'd5;
    localparam logic [2:0] OP_LOAD1      = 3'd6;
    localparam logic [2:0] OP_LOAD2      = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RESULT = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [2:0]    opcode;
        logic [VW-1:0] in1;
        logic [VW-1:0] in2;
    } simd_cmd_t;

    // Loads finish inside the SIMD without ever raising busy or valid.
    function automatic logic is_load_op(input logic [2:0] op);
        return (op == OP_LOAD1) || (op == OP_LOAD2);
    endfunction

endpackage

// File: rtl/simd_cmd_fifo.sv
// Small synchronous FIFO holding queued SIMD commands; the head entry is
// presented combinationally and is only released by an explicit pop.
module simd_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_simd_sequencer.sv
// Issues queued {opcode, in1, in2} commands one at a time to the FP_SIMD unit,
// holds operands until completion and returns results over a valid/ready port.
module fp_simd_sequencer
    import fp_simd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [2:0]    i_cmd_opcode,
    input  logic [VW-1:0] i_cmd_in1,
    input  logic [VW-1:0] i_cmd_in2,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic [VW-1:0] o_res_data,
    output logic [2:0]    o_res_opcode,
    output logic          o_simd_en,
    output logic [2:0]    o_simd_opcode,
    output logic [VW-1:0] o_simd_in1,
    output logic [VW-1:0] o_simd_in2,
    input  logic          i_simd_busy,
    input  logic          i_simd_valid,
    input  logic [VW-1:0] i_simd_output,
    output logic          o_error,
    input  logic          i_clr_error,
    output logic          o_idle
);

    localparam int CW = $clog2(TIMEOUT + 1);

    simd_cmd_t  push_cmd;
    simd_cmd_t  head_cmd;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       timeout_hit;
    seq_state_t state;
    logic [CW-1:0] wait_cnt;

    assign push_cmd = '{opcode: i_cmd_opcode, in1: i_cmd_in1, in2: i_cmd_in2};

    simd_cmd_fifo #(
        .WIDTH ($bits(simd_cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (i_cmd_valid),
        .push_data (push_cmd),
        .pop       (pop),
        .head      (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The SIMD keeps sampling its inputs after issue, so they come straight
    // from the queue head, which is only popped once the command is done.
    assign o_cmd_ready   = !fifo_full;
    assign o_simd_opcode = fifo_empty ? 3'd0 : head_cmd.opcode;
    assign o_simd_in1    = fifo_empty ? '0 : head_cmd.in1;
    assign o_simd_in2    = fifo_empty ? '0 : head_cmd.in2;
    assign o_idle        = fifo_empty && (state == S_IDLE);

    assign timeout_hit = (state == S_WAIT) && !i_simd_valid &&
                         (wait_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        pop = 1'b0;
        case (state)
            S_ISSUE: pop = is_load_op(head_cmd.opcode);
            S_WAIT:  pop = i_simd_valid || timeout_hit;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            o_simd_en    <= 1'b0;
            o_res_valid  <= 1'b0;
            o_res_data   <= '0;
            o_res_opcode <= 3'd0;
            o_error      <= 1'b0;
        end else begin
            // A timeout outranks a simultaneous clear so no abort goes unseen.
            if (timeout_hit) begin
                o_error <= 1'b1;
            end else if (i_clr_error) begin
                o_error <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!fifo_empty && !i_simd_busy && !o_res_valid) begin
                        state     <= S_ISSUE;
                        o_simd_en <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    o_simd_en <= 1'b0;
                    if (is_load_op(head_cmd.opcode)) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_simd_valid) begin
                        o_res_data   <= i_simd_output;
                        o_res_opcode <= head_cmd.opcode;
                        o_res_valid  <= 1'b1;
                        state        <= S_RESULT;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESULT: begin
                    if (i_res_ready) begin
                        o_res_valid <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
